// File: rtl/rx_pcs_pkg.sv
// Shared RX PCS definitions: symbol width, K28.5 comma codes and aligner states.
package rx_pcs_pkg;

    localparam int unsigned SYMBOL_W = 10;

    // K28.5 as held in a symbol register with bit 0 = a (first bit on the wire).
    localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'b0101111100;
    localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'b1010000011;

    typedef enum logic [1:0] {
        HUNT,
        ACQUIRE,
        LOCKED
    } align_state_e;

endpackage

// File: rtl/rx_symbol_aligner_if.sv
// Serial input and aligned-symbol output bundle of the RX word aligner.
interface rx_symbol_aligner_if
    import rx_pcs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SYMBOL_W
) ();

    logic                  Serial_In;
    logic [DATA_WIDTH-1:0] Collected_Data;
    logic                  Symbol_Valid;
    logic                  Comma_Found;
    logic                  Aligned;

    // Bit source / symbol consumer side.
    modport master (
        output Serial_In,
        input  Collected_Data,
        input  Symbol_Valid,
        input  Comma_Found,
        input  Aligned
    );

    // Aligner side.
    modport slave (
        input  Serial_In,
        output Collected_Data,
        output Symbol_Valid,
        output Comma_Found,
        output Aligned
    );

endinterface

// File: rtl/comma_match.sv
// Combinational K28.5 detector covering both running disparities.
module comma_match
    import rx_pcs_pkg::*;
(
    input  logic [SYMBOL_W-1:0] symbol,
    output logic                is_comma
);

    // Exact 10-bit compare against either disparity of K28.5.
    always_comb begin
        is_comma = (symbol == K28_5_RDN) || (symbol == K28_5_RDP);
    end

endmodule

// File: rtl/rx_symbol_aligner.sv
// Serial-to-parallel aligner: hunts for K28.5 at every bit offset, confirms the
// phase over several commas, then emits one aligned symbol every DATA_WIDTH clocks.
module rx_symbol_aligner
    import rx_pcs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = SYMBOL_W,
    parameter int unsigned COMMA_CONFIRM = 4,
    parameter int unsigned MISALIGN_MAX  = 4
) (
    input logic                CLK_5G,
    input logic                Rst_n,
    rx_symbol_aligner_if.slave link
);

    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);
    localparam int unsigned GOOD_W = $clog2(COMMA_CONFIRM + 1);
    localparam int unsigned BAD_W  = $clog2(MISALIGN_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(COMMA_CONFIRM - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST   = BAD_W'(MISALIGN_MAX - 1);
    localparam align_state_e      HUNT_EXIT  = (COMMA_CONFIRM <= 1) ? LOCKED : ACQUIRE;

    logic [DATA_WIDTH-1:0] sr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  comma_q;
    logic                  aligned_q;

    align_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GOOD_W-1:0]     good_q, good_d;
    logic [BAD_W-1:0]      bad_q, bad_d;

    logic                  detect;
    logic                  boundary;
    logic                  emit;

    comma_match u_comma_match (
        .symbol   (sr_q),
        .is_comma (detect)
    );

    assign boundary = (cnt_q == CNT_LAST);

    // Next-state: phase tracking, comma confirmation and misalignment counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        bad_d   = bad_q;
        emit    = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (detect) begin
                    emit    = 1'b1;
                    cnt_d   = '0;
                    good_d  = GOOD_W'(1);
                    state_d = HUNT_EXIT;
                end
            end

            ACQUIRE: begin
                if (boundary) begin
                    emit  = 1'b1;
                    cnt_d = '0;
                    if (detect) begin
                        good_d = good_q + 1'b1;
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // A comma at another offset restarts confirmation on its phase.
                    if (detect) begin
                        emit   = 1'b1;
                        cnt_d  = '0;
                        good_d = GOOD_W'(1);
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    emit  = 1'b1;
                    cnt_d = '0;
                    if (detect) begin
                        bad_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Off-phase commas are tolerated until MISALIGN_MAX of them.
                    if (detect) begin
                        if (bad_q == BAD_LAST) begin
                            state_d = HUNT;
                            cnt_d   = '0;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = HUNT;
                cnt_d   = '0;
                good_d  = '0;
                bad_d   = '0;
            end
        endcase
    end

    // State, shift register and registered symbol outputs.
    always_ff @(posedge CLK_5G or negedge Rst_n) begin
        if (!Rst_n) begin
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            comma_q   <= 1'b0;
            aligned_q <= 1'b0;
            state_q   <= HUNT;
            cnt_q     <= '0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            sr_q      <= {link.Serial_In, sr_q[DATA_WIDTH-1:1]};
            valid_q   <= emit;
            comma_q   <= emit & detect;
            aligned_q <= (state_d == LOCKED);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            if (emit) begin
                data_q <= sr_q;
            end
        end
    end

    assign link.Collected_Data = data_q;
    assign link.Symbol_Valid   = valid_q;
    assign link.Comma_Found    = comma_q;
    assign link.Aligned        = aligned_q;

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// Directed bench for rx_symbol_aligner: table of symbols with the expected emit
// position and outputs per symbol, plus hand-written reset sequences.
module tb_rx_symbol_aligner;

    localparam logic [9:0] CN = 10'h17C;  // K28.5 RD-
    localparam logic [9:0] CP = 10'h283;  // K28.5 RD+
    localparam logic [9:0] DC = 10'h155;  // D21.5, alternating bits
    localparam int         NONE = 99;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rx_symbol_aligner_if #(.DATA_WIDTH(10)) link ();

    rx_symbol_aligner #(
        .DATA_WIDTH    (10),
        .COMMA_CONFIRM (4),
        .MISALIGN_MAX  (4)
    ) dut (
        .CLK_5G (clk),
        .Rst_n  (rst_n),
        .link   (link)
    );

    always #5 clk = ~clk;

    // One record: bits to send (LSB first), bit index after whose edge an emit
    // is expected, the emitted data/comma, and Aligned after the last bit.
    typedef struct {
        logic [9:0] sym;
        int         nbits;
        int         vpos;
        logic [9:0] data;
        logic       comma;
        logic       aligned;
    } vec_t;

    vec_t  vecs[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string tname    = "init";

    task automatic check(input string what, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got 0x%0h, want 0x%0h", tname, what, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        link.Serial_In = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [9:0] sym, input int nbits, input int vpos,
                       input logic [9:0] data, input logic comma, input logic aligned);
        vec_t v;
        v.sym     = sym;
        v.nbits   = nbits;
        v.vpos    = vpos;
        v.data    = data;
        v.comma   = comma;
        v.aligned = aligned;
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].nbits; i++) begin
                send_bit(vecs[k].sym[i]);
                if (i == vecs[k].vpos) begin
                    check($sformatf("v%0d.b%0d.valid", k, i), 10'(link.Symbol_Valid), 10'd1);
                    check($sformatf("v%0d.data", k), link.Collected_Data, vecs[k].data);
                    check($sformatf("v%0d.comma", k), 10'(link.Comma_Found), 10'(vecs[k].comma));
                end else begin
                    check($sformatf("v%0d.b%0d.valid", k, i), 10'(link.Symbol_Valid), 10'd0);
                end
            end
            check($sformatf("v%0d.aligned", k), 10'(link.Aligned), 10'(vecs[k].aligned));
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        link.Serial_In = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_prefix();
        for (int i = 0; i < 3; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            check($sformatf("prefix%0d.valid", i), 10'(link.Symbol_Valid), 10'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        link.Serial_In = 1'b0;

        // Held in reset with random serial data: everything stays clear.
        tname = "reset_hold";
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            link.Serial_In = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("data", link.Collected_Data, 10'h000);
            check("valid", 10'(link.Symbol_Valid), 10'd0);
            check("comma", 10'(link.Comma_Found), 10'd0);
            check("aligned", 10'(link.Aligned), 10'd0);
        end
        link.Serial_In = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Lock acquisition on four RD- commas.
        tname = "lock";
        send_prefix();
        add(CN, 10, NONE, 10'h0, 1'b0, 1'b0);
        add(CN, 10, 0,    CN,    1'b1, 1'b0);
        add(CN, 10, 0,    CN,    1'b1, 1'b0);
        add(CN, 10, 0,    CN,    1'b1, 1'b0);
        add(DC, 10, 0,    CN,    1'b1, 1'b1);
        add(DC, 10, 0,    DC,    1'b0, 1'b1);
        add(DC, 10, 0,    DC,    1'b0, 1'b1);
        run_vecs();

        // Alternating running disparity.
        tname = "mixed_rd";
        do_reset();
        send_prefix();
        add(CN, 10, NONE, 10'h0, 1'b0, 1'b0);
        add(CP, 10, 0,    CN,    1'b1, 1'b0);
        add(CN, 10, 0,    CP,    1'b1, 1'b0);
        add(CP, 10, 0,    CN,    1'b1, 1'b0);
        add(DC, 10, 0,    CP,    1'b1, 1'b1);
        add(DC, 10, 0,    DC,    1'b0, 1'b1);
        run_vecs();

        // Re-phase in ACQUIRE after a 3-bit slip.
        tname = "rephase";
        do_reset();
        send_prefix();
        add(CN,     10, NONE, 10'h0,  1'b0, 1'b0);
        add(CN,     10, 0,    CN,     1'b1, 1'b0);
        add(10'h5,  3,  0,    CN,     1'b1, 1'b0);
        add(CN,     10, 7,    10'h3E5, 1'b0, 1'b0);
        add(CN,     10, 0,    CN,     1'b1, 1'b0);
        add(CN,     10, 0,    CN,     1'b1, 1'b0);
        add(CN,     10, 0,    CN,     1'b1, 1'b0);
        add(DC,     10, 0,    CN,     1'b1, 1'b1);
        add(DC,     10, 0,    DC,     1'b0, 1'b1);
        run_vecs();

        // Loss of lock from a 1-bit slip, then relock on the new phase.
        tname = "lock_loss";
        add(CN,     10, 0,    DC,     1'b0, 1'b1);
        add(10'h0,  1,  0,    CN,     1'b1, 1'b1);
        add(CN,     10, 9,    10'h2F8, 1'b0, 1'b1);
        add(CN,     10, 9,    10'h2F8, 1'b0, 1'b1);
        add(CN,     10, 9,    10'h2F8, 1'b0, 1'b1);
        add(CN,     10, 9,    10'h2F8, 1'b0, 1'b1);
        add(CN,     10, NONE, 10'h0,  1'b0, 1'b0);
        add(CN,     10, 0,    CN,     1'b1, 1'b0);
        add(CN,     10, 0,    CN,     1'b1, 1'b0);
        add(CN,     10, 0,    CN,     1'b1, 1'b0);
        add(DC,     10, 0,    CN,     1'b1, 1'b1);
        add(DC,     10, 0,    DC,     1'b0, 1'b1);
        run_vecs();

        // Asynchronous reset mid-symbol while LOCKED.
        tname = "mid_reset";
        for (int i = 0; i < 4; i++) begin
            send_bit(DC[i]);
        end
        check("pre_data", link.Collected_Data, DC);
        check("pre_aligned", 10'(link.Aligned), 10'd1);
        #2;
        link.Serial_In = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_data", link.Collected_Data, 10'h000);
        check("async_valid", 10'(link.Symbol_Valid), 10'd0);
        check("async_comma", 10'(link.Comma_Found), 10'd0);
        check("async_aligned", 10'(link.Aligned), 10'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        add(DC, 10, NONE, 10'h0, 1'b0, 1'b0);
        add(DC, 10, NONE, 10'h0, 1'b0, 1'b0);
        add(DC, 10, NONE, 10'h0, 1'b0, 1'b0);
        add(CN, 10, NONE, 10'h0, 1'b0, 1'b0);
        add(DC, 10, 0,    CN,    1'b1, 1'b0);
        add(DC, 10, 0,    DC,    1'b0, 1'b0);
        run_vecs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
